button_event_capture: RTL and testbench

- Input-direction peripheral front end: conditions raw board buttons and switches, then exposes their state and latched press events to the CPU side of the peripheral status path.
- Provides the synchronisation, debounce and sticky-event storage the display/LED output side does not need.
- Sits between top-level button/switch pins and the peripheral manager's status bus.
- CPU reads and clears events through a four-phase req/ack handshake.

---
 rtl/button_event_capture.sv | 171 +++++++++++++++++
 tb/tb_button_event_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_capture.sv
// button_event_capture: input-side peripheral front end.
// Synchronises raw buttons and switches, debounces buttons, latches sticky
// press events and serves them to the CPU over a four-phase req/ack read.
// Optional build macro: BUTTON_RELEASE_EVENTS_EN adds sticky release events
// and their read snapshot; event_pending then covers both event sets.
module button_event_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_BUTTONS     = 5,
  parameter int unsigned NUM_SWITCHES    = 16
) (
  input  logic                    clock_100mhz,
  input  logic                    reset,
  input  logic [NUM_BUTTONS-1:0]  buttons_raw,
  input  logic [NUM_SWITCHES-1:0] switches_raw,
  input  logic                    read_req,
  input  logic [NUM_BUTTONS-1:0]  clear_mask,
  output logic                    read_ack,
  output logic [NUM_BUTTONS-1:0]  read_data,
  output logic [NUM_BUTTONS-1:0]  button_level,
  output logic [NUM_BUTTONS-1:0]  press_events,
  output logic [NUM_SWITCHES-1:0] switch_level,
`ifdef BUTTON_RELEASE_EVENTS_EN
  output logic [NUM_BUTTONS-1:0]  release_events,
  output logic [NUM_BUTTONS-1:0]  read_release_data,
`endif
  output logic                    event_pending
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  logic [NUM_BUTTONS-1:0]  btn_s1, btn_s2;
  logic [NUM_SWITCHES-1:0] sw_s1;
  logic [CW-1:0]           cnt_q [NUM_BUTTONS];
  logic [CW-1:0]           cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0]  level_d;
  logic [NUM_BUTTONS-1:0]  rise;
  logic [NUM_BUTTONS-1:0]  press_d;
  state_t                  state_q, state_d;
  logic                    accept;
`ifdef BUTTON_RELEASE_EVENTS_EN
  logic [NUM_BUTTONS-1:0]  fall;
  logic [NUM_BUTTONS-1:0]  release_d;
`endif

  // Two-flop synchronisers; the switch second stage is the switch output
  always_ff @(posedge clock_100mhz or negedge reset) begin
    if (!reset) begin
      btn_s1       <= '0;
      btn_s2       <= '0;
      sw_s1        <= '0;
      switch_level <= '0;
    end else begin
      btn_s1       <= buttons_raw;
      btn_s2       <= btn_s1;
      sw_s1        <= switches_raw;
      switch_level <= sw_s1;
    end
  end

  // Per-button debounce: count disagreeing cycles, accept on the last one
  always_comb begin
    level_d = button_level;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (btn_s2[i] != button_level[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = btn_s2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counter and accepted-level registers
  always_ff @(posedge clock_100mhz or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
      button_level <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      button_level <= level_d;
    end
  end

  // Read FSM state register
  always_ff @(posedge clock_100mhz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state and accept strobe; read_req is ignored in ACK
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_req) begin
          accept  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!read_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next sticky event sets: clear applies first so a same-cycle set wins
  always_comb begin
    rise    = level_d & ~button_level;
    press_d = press_events | rise;
    if (accept) begin
      press_d = (press_events & ~clear_mask) | rise;
    end
`ifdef BUTTON_RELEASE_EVENTS_EN
    fall      = ~level_d & button_level;
    release_d = release_events | fall;
    if (accept) begin
      release_d = (release_events & ~clear_mask) | fall;
    end
`endif
  end

  // Event, snapshot, acknowledge and pending registers
  // read_ack is registered from the next state so it tracks ACK exactly
  always_ff @(posedge clock_100mhz or negedge reset) begin
    if (!reset) begin
      press_events      <= '0;
      read_data         <= '0;
      read_ack          <= 1'b0;
      event_pending     <= 1'b0;
`ifdef BUTTON_RELEASE_EVENTS_EN
      release_events    <= '0;
      read_release_data <= '0;
`endif
    end else begin
      press_events <= press_d;
      read_ack     <= (state_d == ACK);
      if (accept) begin
        read_data <= press_events;
      end
`ifdef BUTTON_RELEASE_EVENTS_EN
      release_events <= release_d;
      if (accept) begin
        read_release_data <= release_events;
      end
      event_pending <= (|press_d) | (|release_d);
`else
      event_pending <= |press_d;
`endif
    end
  end

endmodule

// File: tb/tb_button_event_capture.sv
// Bench for button_event_capture with DEBOUNCE_CYCLES=4.
// A window-based behavioural model runs alongside and is compared every
// cycle; directed literal checks pin the model at the key scenarios.
module tb_button_event_capture;

  localparam int unsigned DEB = 4;
  localparam int unsigned NB  = 5;
  localparam int unsigned NS  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] buttons_raw;
  logic [NS-1:0] switches_raw;
  logic          read_req;
  logic [NB-1:0] clear_mask;
  logic          read_ack;
  logic [NB-1:0] read_data;
  logic [NB-1:0] button_level;
  logic [NB-1:0] press_events;
  logic [NS-1:0] switch_level;
  logic          event_pending;
`ifdef BUTTON_RELEASE_EVENTS_EN
  logic [NB-1:0] release_events;
  logic [NB-1:0] read_release_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  button_event_capture #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_BUTTONS    (NB),
    .NUM_SWITCHES   (NS)
  ) dut (
    .clock_100mhz     (clk),
    .reset            (rst_n),
    .buttons_raw      (buttons_raw),
    .switches_raw     (switches_raw),
    .read_req         (read_req),
    .clear_mask       (clear_mask),
    .read_ack         (read_ack),
    .read_data        (read_data),
    .button_level     (button_level),
    .press_events     (press_events),
    .switch_level     (switch_level),
`ifdef BUTTON_RELEASE_EVENTS_EN
    .release_events   (release_events),
    .read_release_data(read_release_data),
`endif
    .event_pending    (event_pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NB-1:0] m_lvl, m_pe, m_re, m_rd, m_rrd;
  logic [NS-1:0] m_sw, m_sw1;
  logic          m_ack, m_pend;
  logic [NB-1:0] bq[$];

  task automatic model_reset();
    m_lvl = '0; m_pe = '0; m_re = '0; m_rd = '0; m_rrd = '0;
    m_sw = '0; m_sw1 = '0; m_ack = 1'b0; m_pend = 1'b0;
    bq.delete();
    for (int k = 0; k < int'(DEB) + 2; k++) bq.push_back('0);
  endtask

  // A level flips once the last DEB synchronised samples (raw delayed by
  // two edges) all disagree with it.
  task automatic model_step();
    logic [NB-1:0] nl, rs, fl;
    logic          acc, all_diff;
    acc = !m_ack && read_req;
    bq.push_front(buttons_raw);
    void'(bq.pop_back());
    nl = m_lvl;
    for (int b = 0; b < int'(NB); b++) begin
      all_diff = 1'b1;
      for (int k = 2; k < int'(DEB) + 2; k++)
        if (bq[k][b] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) nl[b] = ~m_lvl[b];
    end
    rs = nl & ~m_lvl;
    fl = m_lvl & ~nl;
    if (acc) begin
      m_rd  = m_pe;
      m_rrd = m_re;
      m_pe  = (m_pe & ~clear_mask) | rs;
      m_re  = (m_re & ~clear_mask) | fl;
      m_ack = 1'b1;
    end else begin
      m_pe = m_pe | rs;
      m_re = m_re | fl;
      if (m_ack && !read_req) m_ack = 1'b0;
    end
    m_lvl = nl;
`ifdef BUTTON_RELEASE_EVENTS_EN
    m_pend = (|m_pe) | (|m_re);
`else
    m_pend = |m_pe;
`endif
    m_sw  = m_sw1;
    m_sw1 = switches_raw;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("button_level", button_level, m_lvl);
        chk("press_events", press_events, m_pe);
        chk("switch_level", switch_level, m_sw);
        chk("event_pending", event_pending, m_pend);
        chk("read_ack", read_ack, m_ack);
        chk("read_data", read_data, m_rd);
`ifdef BUTTON_RELEASE_EVENTS_EN
        chk("release_events", release_events, m_re);
        chk("read_release_data", read_release_data, m_rrd);
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n        = 1'b1;
    buttons_raw  = NB'($urandom);
    switches_raw = NS'($urandom);
    read_req     = 1'b0;
    clear_mask   = '0;
    #1 rst_n = 1'b0;
    step(3);
    chk("rst_level", button_level, 0);
    chk("rst_press", press_events, 0);
    chk("rst_switch", switch_level, 0);
    chk("rst_pending", event_pending, 0);
    chk("rst_ack", read_ack, 0);
    chk("rst_rdata", read_data, 0);
    mon_en = 1'b1;

    buttons_raw  = '0;
    switches_raw = 16'hA5C3;
    rst_n        = 1'b1;
    step(1);
    chk("sw_lat1", switch_level, 0);
    step(1);
    chk("sw_lat2", switch_level, 16'hA5C3);

    // glitch shorter than the debounce window
    buttons_raw = 5'b00001;
    step(3);
    buttons_raw = '0;
    step(8);
    chk("glitch_level", button_level, 0);
    chk("glitch_press", press_events, 0);

    // clean press on button 2: accepted exactly 6 edges after the raw edge
    buttons_raw = 5'b00100;
    step(5);
    chk("press_early", button_level[2], 0);
    step(1);
    chk("press_level", button_level, 5'b00100);
    chk("press_event", press_events, 5'b00100);
    chk("press_pending", event_pending, 1);
    step(14);
    buttons_raw = '0;
    step(8);
    chk("release_level", button_level, 0);
    chk("sticky_press", press_events, 5'b00100);

    // press button 0 to reach 00101
    buttons_raw = 5'b00001;
    step(8);
    buttons_raw = '0;
    step(8);
    chk("two_events", press_events, 5'b00101);

    // read with clear of bit 0
    read_req   = 1'b1;
    clear_mask = 5'b00001;
    step(1);
    chk("rd_ack", read_ack, 1);
    chk("rd_data", read_data, 5'b00101);
    chk("rd_cleared", press_events, 5'b00100);
    read_req   = 1'b0;
    clear_mask = '0;
    step(1);
    chk("rd_ack_drop", read_ack, 0);
    step(1);

    // set wins: button 1 accept lands on the read accept edge
    buttons_raw = 5'b00010;
    step(5);
    read_req   = 1'b1;
    clear_mask = 5'b00010;
    step(1);
    chk("sw_ack", read_ack, 1);
    chk("sw_rdata", read_data, 5'b00100);
    chk("sw_press", press_events, 5'b00110);
    read_req   = 1'b0;
    clear_mask = '0;
    step(1);
    chk("sw_ack_drop", read_ack, 0);
    buttons_raw = '0;
    step(8);

    // clear_mask=0 read; an event arriving during ACK leaves read_data alone
    read_req = 1'b1;
    step(1);
    chk("nc_ack", read_ack, 1);
    chk("nc_rdata", read_data, 5'b00110);
    chk("nc_press", press_events, 5'b00110);
    buttons_raw = 5'b01000;
    step(6);
    chk("ack_evt_press", press_events, 5'b01110);
    chk("ack_evt_rdata", read_data, 5'b00110);
    chk("ack_held", read_ack, 1);

    // asynchronous reset during ACK
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", read_ack, 0);
    chk("arst_press", press_events, 0);
    buttons_raw = '0;
    read_req    = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    read_req = 1'b1;
    chk("post_rst_idle", read_ack, 0);
    step(1);
    chk("post_rst_ack", read_ack, 1);
    chk("post_rst_rdata", read_data, 0);
    read_req = 1'b0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
